mem_port_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 10 +
 rtl/mem_port_arbiter_if.sv | 36 +++
 rtl/mem_lat_counter.sv | 34 +++
 rtl/mem_port_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory port arbiter.
package mem_arb_pkg;

    typedef enum logic {IDLE, ACCESS} state_t;
    typedef enum logic {OWN_IF, OWN_DM} owner_t;

    localparam int MEM_LAT_DEF = 2;
    localparam int CNT_W       = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between pipeline stages, arbiter and the single-ported memory.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic              if_valid;
    logic [31:0]       if_rdata;
    logic              dm_read;
    logic              dm_write;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_valid;
    logic [DATA_W-1:0] dm_rdata;
    logic              stall;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter view.
    modport slave (
        input  if_req, if_addr, if_flush, dm_read, dm_write, dm_addr, dm_wdata, mem_rdata,
        output if_valid, if_rdata, dm_valid, dm_rdata, stall, mem_en, mem_we, mem_addr, mem_wdata
    );

    // Pipeline-plus-memory view.
    modport master (
        output if_req, if_addr, if_flush, dm_read, dm_write, dm_addr, dm_wdata, mem_rdata,
        input  if_valid, if_rdata, dm_valid, dm_rdata, stall, mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_lat_counter.sv
// Fixed-latency access counter: loads 1 on issue, counts up, flags cnt == MEM_LAT.
module mem_lat_counter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT = MEM_LAT_DEF
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_tc
);

    localparam logic [CNT_W-1:0] TC = CNT_W'(MEM_LAT);

    logic [CNT_W-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= CNT_W'(1);
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_tc = (r_cnt == TC);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory between IF and MEM; data wins, pipeline stalls until all requesters are served.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT = MEM_LAT_DEF,
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64
) (
    input  logic               i_clk,
    input  logic               i_rst,
    mem_port_arbiter_if.slave  io_bus
);

    state_t            r_state, w_state_nxt;
    owner_t            r_owner, w_owner_nxt;
    logic              r_if_done, r_dm_done, r_if_stale;
    logic [31:0]       r_if_buf;
    logic [DATA_W-1:0] r_dm_buf;

    logic              w_dm_any, w_advance, w_issue_dm, w_issue_if, w_capture, w_cnt_tc;
    logic [ADDR_W-1:0] w_issue_addr;

    assign w_dm_any  = io_bus.dm_read | io_bus.dm_write;
    assign w_advance = (io_bus.if_req | w_dm_any) & (~io_bus.if_req | r_if_done)
                     & (~w_dm_any | r_dm_done);

    mem_lat_counter #(.MEM_LAT(MEM_LAT)) u_cnt (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_load (w_issue_dm | w_issue_if),
        .i_inc  (r_state == ACCESS),
        .i_clr  (w_capture),
        .o_tc   (w_cnt_tc)
    );

    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt      = r_state;
        w_owner_nxt      = r_owner;
        w_issue_dm       = 1'b0;
        w_issue_if       = 1'b0;
        w_capture        = 1'b0;
        w_issue_addr     = '0;
        io_bus.mem_en    = 1'b0;
        io_bus.mem_we    = 1'b0;
        io_bus.mem_wdata = '0;
        case (r_state)
            IDLE: begin
                if (w_dm_any && !r_dm_done) begin
                    w_issue_dm       = 1'b1;
                    w_owner_nxt      = OWN_DM;
                    w_state_nxt      = ACCESS;
                    io_bus.mem_en    = 1'b1;
                    io_bus.mem_we    = io_bus.dm_write;
                    io_bus.mem_wdata = io_bus.dm_wdata;
                    w_issue_addr     = io_bus.dm_addr;
                end else if (io_bus.if_req && !r_if_done) begin
                    w_issue_if       = 1'b1;
                    w_owner_nxt      = OWN_IF;
                    w_state_nxt      = ACCESS;
                    io_bus.mem_en    = 1'b1;
                    w_issue_addr     = io_bus.if_addr;
                end
            end
            ACCESS: begin
                if (w_cnt_tc) begin
                    w_capture   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        io_bus.mem_addr = w_issue_addr;
        io_bus.stall    = (io_bus.if_req | w_dm_any) & ~w_advance;
        io_bus.if_valid = w_advance & io_bus.if_req & ~io_bus.if_flush;
        io_bus.dm_valid = w_advance & w_dm_any;
        io_bus.if_rdata = io_bus.if_valid ? r_if_buf : '0;
        io_bus.dm_rdata = io_bus.dm_valid ? r_dm_buf : '0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_owner    <= OWN_IF;
            r_if_done  <= 1'b0;
            r_dm_done  <= 1'b0;
            r_if_stale <= 1'b0;
            r_if_buf   <= '0;
            r_dm_buf   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            if (w_advance) begin
                r_if_done <= 1'b0;
                r_dm_done <= 1'b0;
                r_if_buf  <= '0;
                r_dm_buf  <= '0;
            end
            if (w_capture) begin
                if (r_owner == OWN_DM) begin
                    r_dm_done <= 1'b1;
                    r_dm_buf  <= io_bus.dm_write ? '0 : io_bus.mem_rdata;
                end else if (!r_if_stale && !io_bus.if_flush) begin
                    r_if_done <= 1'b1;
                    r_if_buf  <= io_bus.mem_rdata[31:0];
                end
            end
            if (io_bus.if_flush) begin
                r_if_done <= 1'b0;
                r_if_buf  <= '0;
            end
            // A flush while IF owns the port poisons that fetch until its capture.
            if (w_issue_if) begin
                r_if_stale <= io_bus.if_flush;
            end else if (w_capture) begin
                r_if_stale <= 1'b0;
            end else if (io_bus.if_flush && r_state == ACCESS && r_owner == OWN_IF) begin
                r_if_stale <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter with a fixed-latency memory model.
module tb_mem_port_arbiter;

    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

    mem_port_arbiter #(.MEM_LAT(LAT), .ADDR_W(64), .DATA_W(64)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus)
    );

    function automatic logic [63:0] mem_word(input logic [63:0] a);
        case (a)
            64'h10:  return 64'h0000_0000_00A0_0093;
            64'h14:  return 64'h1111_2222_0040_0113;
            64'h20:  return 64'hCAFE_F00D_1234_5678;
            64'h30:  return 64'h0123_4567_89AB_CDEF;
            64'h40:  return 64'h0000_0000_0BAD_0BAD;
            64'h80:  return 64'h0000_0000_0050_0193;
            default: return {32'h5A5A_5A5A, a[31:0]};
        endcase
    endfunction

    // Memory model: read data appears LAT cycles after the mem_en sample edge, junk otherwise.
    logic [LAT-1:0] dv = '0;
    logic [63:0]    dd [LAT];
    logic [63:0]    wr_addr = '0;
    logic [63:0]    wr_data = '0;
    always @(posedge clk) begin
        dv    <= {dv[LAT-2:0], bus.mem_en & ~bus.mem_we};
        dd[0] <= mem_word(bus.mem_addr);
        for (int k = 1; k < LAT; k++) dd[k] <= dd[k-1];
        if (bus.mem_en && bus.mem_we) begin
            wr_addr <= bus.mem_addr;
            wr_data <= bus.mem_wdata;
        end
    end
    assign bus.mem_rdata = dv[LAT-1] ? dd[LAT-1] : 64'hBAD0_BAD0_BAD0_BAD0;

    typedef struct {
        logic        rst;
        logic        ifr;
        logic [63:0] ifa;
        logic        fl;
        logic        dr;
        logic        dw;
        logic [63:0] da;
        logic [63:0] dwd;
        logic        e_stall;
        logic        e_en;
        logic        e_we;
        logic [63:0] e_addr;
        logic [63:0] e_wdata;
        logic        e_ifv;
        logic [31:0] e_ifd;
        logic        e_dmv;
        logic [63:0] e_dmd;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst_i, input logic ifr, input logic [63:0] ifa, input logic fl,
                       input logic dr, input logic dw, input logic [63:0] da, input logic [63:0] dwd,
                       input logic e_stall, input logic e_en, input logic e_we,
                       input logic [63:0] e_addr, input logic [63:0] e_wdata,
                       input logic e_ifv, input logic [31:0] e_ifd,
                       input logic e_dmv, input logic [63:0] e_dmd);
        vec_t v;
        v = '{rst_i, ifr, ifa, fl, dr, dw, da, dwd, e_stall, e_en, e_we, e_addr, e_wdata,
              e_ifv, e_ifd, e_dmv, e_dmd};
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic ifr, input logic [63:0] ifa, input logic fl,
                         input logic dr, input logic dw, input logic [63:0] da, input logic [63:0] dwd);
        rst          = r;
        bus.if_req   = ifr;
        bus.if_addr  = ifa;
        bus.if_flush = fl;
        bus.dm_read  = dr;
        bus.dm_write = dw;
        bus.dm_addr  = da;
        bus.dm_wdata = dwd;
    endtask

    initial begin
        // Reset state and idle
        add(1, 0, 0,     0, 0, 0, 0,     0,            0, 0, 0, 0,     0,            0, 0,            0, 0);
        add(0, 0, 0,     0, 0, 0, 0,     0,            0, 0, 0, 0,     0,            0, 0,            0, 0);
        // Single IF access
        add(0, 1, 'h10,  0, 0, 0, 0,     0,            1, 1, 0, 'h10,  0,            0, 0,            0, 0);
        add(0, 1, 'h10,  0, 0, 0, 0,     0,            1, 0, 0, 0,     0,            0, 0,            0, 0);
        add(0, 1, 'h10,  0, 0, 0, 0,     0,            1, 0, 0, 0,     0,            0, 0,            0, 0);
        add(0, 1, 'h10,  0, 0, 0, 0,     0,            0, 0, 0, 0,     0,            1, 32'h00A00093, 0, 0);
        add(0, 0, 0,     0, 0, 0, 0,     0,            0, 0, 0, 0,     0,            0, 0,            0, 0);
        // DM read and IF together: data first
        add(0, 1, 'h14,  0, 1, 0, 'h20,  0,            1, 1, 0, 'h20,  0,            0, 0,            0, 0);
        add(0, 1, 'h14,  0, 1, 0, 'h20,  0,            1, 0, 0, 0,     0,            0, 0,            0, 0);
        add(0, 1, 'h14,  0, 1, 0, 'h20,  0,            1, 0, 0, 0,     0,            0, 0,            0, 0);
        add(0, 1, 'h14,  0, 1, 0, 'h20,  0,            1, 1, 0, 'h14,  0,            0, 0,            0, 0);
        add(0, 1, 'h14,  0, 1, 0, 'h20,  0,            1, 0, 0, 0,     0,            0, 0,            0, 0);
        add(0, 1, 'h14,  0, 1, 0, 'h20,  0,            1, 0, 0, 0,     0,            0, 0,            0, 0);
        add(0, 1, 'h14,  0, 1, 0, 'h20,  0,            0, 0, 0, 0,     0,            1, 32'h00400113, 1, 64'hCAFEF00D12345678);
        add(0, 0, 0,     0, 0, 0, 0,     0,            0, 0, 0, 0,     0,            0, 0,            0, 0);
        // Store
        add(0, 0, 0,     0, 0, 1, 'h28,  'hDEADBEEF,   1, 1, 1, 'h28,  'hDEADBEEF,   0, 0,            0, 0);
        add(0, 0, 0,     0, 0, 1, 'h28,  'hDEADBEEF,   1, 0, 0, 0,     0,            0, 0,            0, 0);
        add(0, 0, 0,     0, 0, 1, 'h28,  'hDEADBEEF,   1, 0, 0, 0,     0,            0, 0,            0, 0);
        add(0, 0, 0,     0, 0, 1, 'h28,  'hDEADBEEF,   0, 0, 0, 0,     0,            0, 0,            1, 0);
        add(0, 0, 0,     0, 0, 0, 0,     0,            0, 0, 0, 0,     0,            0, 0,            0, 0);
        // Flush mid-access: stale capture dropped, re-issue to the new PC
        add(0, 1, 'h40,  0, 0, 0, 0,     0,            1, 1, 0, 'h40,  0,            0, 0,            0, 0);
        add(0, 1, 'h80,  1, 0, 0, 0,     0,            1, 0, 0, 0,     0,            0, 0,            0, 0);
        add(0, 1, 'h80,  0, 0, 0, 0,     0,            1, 0, 0, 0,     0,            0, 0,            0, 0);
        add(0, 1, 'h80,  0, 0, 0, 0,     0,            1, 1, 0, 'h80,  0,            0, 0,            0, 0);
        add(0, 1, 'h80,  0, 0, 0, 0,     0,            1, 0, 0, 0,     0,            0, 0,            0, 0);
        add(0, 1, 'h80,  0, 0, 0, 0,     0,            1, 0, 0, 0,     0,            0, 0,            0, 0);
        add(0, 1, 'h80,  0, 0, 0, 0,     0,            0, 0, 0, 0,     0,            1, 32'h00500193, 0, 0);
        add(0, 0, 0,     0, 0, 0, 0,     0,            0, 0, 0, 0,     0,            0, 0,            0, 0);
        // Flush in the advance cycle suppresses if_valid
        add(0, 1, 'h10,  0, 0, 0, 0,     0,            1, 1, 0, 'h10,  0,            0, 0,            0, 0);
        add(0, 1, 'h10,  0, 0, 0, 0,     0,            1, 0, 0, 0,     0,            0, 0,            0, 0);
        add(0, 1, 'h10,  0, 0, 0, 0,     0,            1, 0, 0, 0,     0,            0, 0,            0, 0);
        add(0, 1, 'h10,  1, 0, 0, 0,     0,            0, 0, 0, 0,     0,            0, 0,            0, 0);
        add(0, 0, 0,     0, 0, 0, 0,     0,            0, 0, 0, 0,     0,            0, 0,            0, 0);
        // Reset mid DM access; stale response must not complete the next load
        add(0, 0, 0,     0, 1, 0, 'h20,  0,            1, 1, 0, 'h20,  0,            0, 0,            0, 0);
        add(1, 0, 0,     0, 1, 0, 'h20,  0,            1, 0, 0, 0,     0,            0, 0,            0, 0);
        add(0, 0, 0,     0, 0, 0, 0,     0,            0, 0, 0, 0,     0,            0, 0,            0, 0);
        add(0, 0, 0,     0, 1, 0, 'h30,  0,            1, 1, 0, 'h30,  0,            0, 0,            0, 0);
        add(0, 0, 0,     0, 1, 0, 'h30,  0,            1, 0, 0, 0,     0,            0, 0,            0, 0);
        add(0, 0, 0,     0, 1, 0, 'h30,  0,            1, 0, 0, 0,     0,            0, 0,            0, 0);
        add(0, 0, 0,     0, 1, 0, 'h30,  0,            0, 0, 0, 0,     0,            0, 0,            1, 64'h0123456789ABCDEF);
        // Ten idle cycles
        for (int k = 0; k < 10; k++)
            add(0, 0, 0, 0, 0, 0, 0, 0,                 0, 0, 0, 0,     0,            0, 0,            0, 0);

        drive(1, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].ifr, vecs[i].ifa, vecs[i].fl,
                  vecs[i].dr, vecs[i].dw, vecs[i].da, vecs[i].dwd);
            @(negedge clk);
            check($sformatf("v%0d stall", i),     64'(bus.stall),     64'(vecs[i].e_stall));
            check($sformatf("v%0d mem_en", i),    64'(bus.mem_en),    64'(vecs[i].e_en));
            check($sformatf("v%0d mem_we", i),    64'(bus.mem_we),    64'(vecs[i].e_we));
            check($sformatf("v%0d mem_addr", i),  bus.mem_addr,       vecs[i].e_addr);
            check($sformatf("v%0d mem_wdata", i), bus.mem_wdata,      vecs[i].e_wdata);
            check($sformatf("v%0d if_valid", i),  64'(bus.if_valid),  64'(vecs[i].e_ifv));
            check($sformatf("v%0d if_rdata", i),  64'(bus.if_rdata),  64'(vecs[i].e_ifd));
            check($sformatf("v%0d dm_valid", i),  64'(bus.dm_valid),  64'(vecs[i].e_dmv));
            check($sformatf("v%0d dm_rdata", i),  bus.dm_rdata,       vecs[i].e_dmd);
            @(posedge clk);
            #1;
        end
        check("store wr_addr", wr_addr, 64'h28);
        check("store wr_data", wr_data, 64'hDEADBEEF);

        // Read+write together counts as a write, and still beats a pending fetch.
        begin
            int  adv_cycle;
            bit  seen;
            seen      = 1'b0;
            adv_cycle = -1;
            drive(0, 1, 'h10, 0, 1, 1, 'h50, 'h1234);
            for (int c = 0; c < 20 && !seen; c++) begin
                @(negedge clk);
                if (c == 0) begin
                    check("rw issue mem_en", 64'(bus.mem_en), 64'd1);
                    check("rw issue mem_we", 64'(bus.mem_we), 64'd1);
                    check("rw issue addr",   bus.mem_addr,    64'h50);
                end
                if (!bus.stall) begin
                    seen      = 1'b1;
                    adv_cycle = c;
                    check("rw if_valid", 64'(bus.if_valid), 64'd1);
                    check("rw if_rdata", 64'(bus.if_rdata), 64'h00A00093);
                    check("rw dm_valid", 64'(bus.dm_valid), 64'd1);
                    check("rw dm_rdata", bus.dm_rdata,      64'd0);
                end
                @(posedge clk);
                #1;
            end
            check("rw advance seen",  64'(seen),      64'd1);
            check("rw advance cycle", 64'(adv_cycle), 64'd6);
            check("rw wr_addr",       wr_addr,        64'h50);
            check("rw wr_data",       wr_data,        64'h1234);
            drive(0, 0, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            check("rw idle stall", 64'(bus.stall), 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
